serial_loader: RTL and testbench
================================

// Module: serial_loader
// PURPOSE
//  Host-side master for the pattern-buffer serial load port (sclk/sin/ssel/saddr/sout).
//  Accepts buffer_size bytes on a valid/ready stream, serialises them MSB-first into the
//  addressed buffer chain, and frames the transfer with ssel. It is the transmitting end
//  for the buffers block; sits between the control/host logic and the buffer array.
// PARAMETERS
//  buffer_size   12  bytes per frame (one byte per buffer entry)
//  buffer_width  8   bits per byte; width of byte_in / rb_byte
//  CLK_DIV       2   clk cycles per sclk half-period; legal range 1..255
// PORTS
//  clk         in   1             system clock; all logic on posedge
//  reset       in   1             synchronous, active-high reset
//  start       in   1             pulse: begin frame (ignored unless idle)
//  addr_in     in   3             buffer address, latched onto saddr at start
//  busy        out  1             high from accepted start until done
//  done        out  1             one-cycle pulse at end of frame
//  byte_in     in   buffer_width  next byte to send
//  byte_valid  in   1             byte_in valid
//  byte_ready  out  1             loader can take a byte this cycle
//  sclk        out  1             serial clock to buffers, idles low
//  sin         out  1             serial data to buffers
//  ssel        out  1             select, active-high, frames whole transfer
//  saddr       out  3             buffer address, stable while ssel high
//  sout        in   1             serial data returned from buffers
// BEHAVIOUR
//  - Reset: busy=0 done=0 byte_ready=0 sclk=0 sin=0 ssel=0 saddr=0; counters=0; state IDLE.
//  - States: IDLE -> SETUP -> FETCH -> SHIFT_LO -> SHIFT_HI -> (SHIFT_LO|FETCH|TAIL) -> IDLE.
//  - IDLE: start=1 -> next cycle saddr<=addr_in, ssel=1, busy=1, byte count=0, enter SETUP.
//  - SETUP: sclk=0 for CLK_DIV cycles (select-to-first-edge setup), then FETCH.
//  - FETCH: byte_ready=1, sclk held 0; transfer on byte_valid&&byte_ready loads shift reg,
//    bit count=0, enter SHIFT_LO. Stalling (valid low) is legal; ssel stays high.
//  - byte_ready is 1 only in FETCH; never asserted in any other state.
//  - SHIFT_LO: sin=shift[MSB], sclk=0 for CLK_DIV cycles; then SHIFT_HI.
//  - SHIFT_HI: sclk=1 for CLK_DIV cycles; sin stable. Last cycle: shift reg <<1,
//    bit count+1. Bit count==buffer_width -> byte count+1; byte count==buffer_size -> TAIL,
//    else FETCH. Otherwise SHIFT_LO. Each bit = 2*CLK_DIV clk cycles.
//  - sin changes only while sclk=0; saddr changes only while ssel=0.
//  - TAIL: sclk=0 for CLK_DIV cycles, then ssel=0, busy=0, done=1 for one cycle, IDLE.
//  - start while busy: ignored, no effect on frame. start same cycle as done: ignored.
//  - byte_valid outside FETCH: ignored (not consumed).
//  - Reset mid-frame: next cycle all outputs at reset values, no done pulse, frame dropped.
//  - Counters sized for buffer_size/buffer_width exactly; no wrap within a frame.
// CONFIGURATION
//  READBACK_EN defined: adds outputs rb_valid (1) and rb_byte (buffer_width).
//    sout sampled on the clk cycle sclk goes 0->1 (first SHIFT_HI cycle), shifted into
//    rb shift reg LSB-in; after buffer_width samples rb_byte updates and rb_valid pulses
//    one cycle (same cycle the byte count increments). rb_valid=0, rb_byte=0 on reset.
//  READBACK_EN undefined: sout unused, no rb_* ports, no readback logic.
// TESTING
//  1 reset then idle 20 cycles -> ssel=sclk=sin=0, busy=0, byte_ready=0, done never 1.
//  2 CLK_DIV=2, start addr_in=3'd5, valid always, bytes 8'hA5..: -> saddr=5, sin bits
//    1,0,1,0,0,1,0,1 each 4 cycles, sclk 2 low/2 high, 12 ready handshakes, one done.
//  3 valid low 10 cycles before byte 4 -> sclk stays 0, ssel stays 1 throughout stall,
//    frame resumes with correct byte, bit stream identical to test 2.
//  4 start pulsed again mid-frame with addr_in=3'd2 -> ignored, saddr stays 5, 12 bytes.
//  5 reset asserted after byte 6 bit 3 -> next cycle ssel=0 sclk=0 busy=0, no done;
//    new start afterwards completes a full 12-byte frame.
//  6 READBACK_EN, sout looped to delayed sin model returning 8'h3C -> rb_valid pulse
//    per byte, rb_byte=8'h3C; without macro, bench compiles without rb_* ports.

Source files
------------

// File: rtl/serial_loader_if.sv
// Host stream, control and serial-bus bundle for serial_loader.
// rb_valid/rb_byte are present only when READBACK_EN is defined.
interface serial_loader_if #(
    parameter int buffer_width = 8
);
    logic                    start;
    logic [2:0]              addr_in;
    logic                    busy;
    logic                    done;
    logic [buffer_width-1:0] byte_in;
    logic                    byte_valid;
    logic                    byte_ready;
    logic                    sclk;
    logic                    sin;
    logic                    ssel;
    logic [2:0]              saddr;
    logic                    sout;
`ifdef READBACK_EN
    logic                    rb_valid;
    logic [buffer_width-1:0] rb_byte;
`endif

    modport slave (
        input  start,
        input  addr_in,
        input  byte_in,
        input  byte_valid,
        input  sout,
`ifdef READBACK_EN
        output rb_valid,
        output rb_byte,
`endif
        output busy,
        output done,
        output byte_ready,
        output sclk,
        output sin,
        output ssel,
        output saddr
    );

    modport master (
        output start,
        output addr_in,
        output byte_in,
        output byte_valid,
        output sout,
`ifdef READBACK_EN
        input  rb_valid,
        input  rb_byte,
`endif
        input  busy,
        input  done,
        input  byte_ready,
        input  sclk,
        input  sin,
        input  ssel,
        input  saddr
    );
endinterface

// File: rtl/serial_loader.sv
// Serial load master: streams buffer_size bytes MSB-first into the addressed buffer chain.
// Optional READBACK_EN captures sout on each sclk rise into rb_byte/rb_valid.
module serial_loader #(
    parameter int buffer_size  = 12,
    parameter int buffer_width = 8,
    parameter int CLK_DIV      = 2
) (
    input  logic           clk,
    input  logic           reset,
    serial_loader_if.slave bus
);
    localparam int BIT_W  = $clog2(buffer_width + 1);
    localparam int BYTE_W = $clog2(buffer_size + 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        FETCH,
        SHIFT_LO,
        SHIFT_HI,
        TAIL
    } state_t;

    state_t                  state;
    state_t                  state_nx;
    logic [7:0]              div_cnt;
    logic [buffer_width-1:0] shift;
    logic [BIT_W-1:0]        bit_cnt;
    logic [BYTE_W-1:0]       byte_cnt;
    logic [2:0]              saddr_r;
    logic                    done_r;

    logic div_last;
    logic accept;
    logic xfer;
    logic bit_end;
    logic byte_end;
    logic frame_end;

    assign div_last  = div_cnt == 8'(CLK_DIV - 1);
    assign accept    = state == IDLE && bus.start && !done_r;
    assign xfer      = state == FETCH && bus.byte_valid;
    assign bit_end   = state == SHIFT_HI && div_last;
    assign byte_end  = bit_end
                    && bit_cnt == BIT_W'(buffer_width - 1);
    assign frame_end = byte_end
                    && byte_cnt == BYTE_W'(buffer_size - 1);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:     if (accept)     state_nx = SETUP;
            SETUP:    if (div_last)   state_nx = FETCH;
            FETCH:    if (xfer)       state_nx = SHIFT_LO;
            SHIFT_LO: if (div_last)   state_nx = SHIFT_HI;
            SHIFT_HI: begin
                if (frame_end)        state_nx = TAIL;
                else if (byte_end)    state_nx = FETCH;
                else if (bit_end)     state_nx = SHIFT_LO;
            end
            TAIL:     if (div_last)   state_nx = IDLE;
            default:                  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt  <= '0;
            shift    <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            saddr_r  <= '0;
            done_r   <= 1'b0;
        end else begin
            done_r  <= state == TAIL && div_last;
            div_cnt <= (state_nx != state) ? '0 : div_cnt + 8'd1;
            if (accept) begin
                saddr_r  <= bus.addr_in;
                byte_cnt <= '0;
            end
            if (xfer) begin
                shift   <= bus.byte_in;
                bit_cnt <= '0;
            end
            if (bit_end) begin
                shift   <= shift << 1;
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (byte_end) byte_cnt <= byte_cnt + 1'b1;
        end
    end

    // shift is all-zero outside a byte, so sin idles low
    assign bus.busy       = state != IDLE;
    assign bus.ssel       = state != IDLE;
    assign bus.byte_ready = state == FETCH;
    assign bus.sclk       = state == SHIFT_HI;
    assign bus.sin        = shift[buffer_width-1];
    assign bus.saddr      = saddr_r;
    assign bus.done       = done_r;

`ifdef READBACK_EN
    logic [buffer_width-1:0] rb_shift;
    logic [buffer_width-1:0] rb_next;
    logic [buffer_width-1:0] rb_byte_r;
    logic                    rb_valid_r;

    always_comb begin
        rb_next = rb_shift;
        if (state == SHIFT_HI && div_cnt == '0)
            rb_next = {rb_shift[buffer_width-2:0], bus.sout};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rb_shift   <= '0;
            rb_byte_r  <= '0;
            rb_valid_r <= 1'b0;
        end else begin
            rb_shift   <= rb_next;
            rb_valid_r <= byte_end;
            if (byte_end) rb_byte_r <= rb_next;
        end
    end

    assign bus.rb_valid = rb_valid_r;
    assign bus.rb_byte  = rb_byte_r;
`endif
endmodule

// File: tb/tb_serial_loader.sv
// Directed/random bench for serial_loader against a frame-level model.
// Define READBACK_EN to also exercise the readback path.
module tb_serial_loader;
    localparam int SIZE = 12;
    localparam int W    = 8;
    localparam int DIV  = 2;
    localparam int FRM  = DIV + SIZE * (1 + 2 * DIV * W) + DIV;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    serial_loader_if #(.buffer_width(W)) bus();

    serial_loader #(
        .buffer_size (SIZE),
        .buffer_width(W),
        .CLK_DIV     (DIV)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] tx [SIZE];
    logic exp_bits [$];
    logic got_bits [$];

    int hs, dones, ssel_cyc, rises;
    int hi_bad, lo_bad, sin_bad;
    int saddr_bad, busy_bad, ready_bad;
    int rb_cnt, rb_bad;
    bit timed_out;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic new_bytes(input logic [W-1:0] first);
        tx[0] = first;
        for (int i = 1; i < SIZE; i++) tx[i] = W'($urandom);
        exp_bits.delete();
        foreach (tx[i])
            for (int b = W - 1; b >= 0; b--)
                exp_bits.push_back(tx[i][b]);
    endtask

    function automatic int stream_diff();
        int d = 0;
        if (got_bits.size() != exp_bits.size()) return -1;
        foreach (exp_bits[k])
            if (got_bits[k] !== exp_bits[k]) d++;
        return d;
    endfunction

    task automatic run_frame(input logic [2:0] addr,
                             input int stall_byte,
                             input int mid_cyc,
                             input int reset_rise);
        int i = 0;
        int stall_left = 0;
        int hi_run = 0;
        int lo_run = 0;
        int c;
        bit fired = 0;
        bit stalled = 0;
        logic psclk = 0;
        logic psin = 0;
        logic [W-1:0] pat = 8'h3C;
        hs = 0; dones = 0; ssel_cyc = 0; rises = 0;
        hi_bad = 0; lo_bad = 0; sin_bad = 0;
        saddr_bad = 0; busy_bad = 0; ready_bad = 0;
        rb_cnt = 0; rb_bad = 0;
        got_bits.delete();
        @(negedge clk);
        bus.start      = 1'b1;
        bus.addr_in    = addr;
        bus.byte_valid = 1'b1;
        bus.byte_in    = tx[0];
        for (c = 1; c <= 3000; c++) begin
            @(negedge clk);
            bus.start = (c == mid_cyc);
            if (c == mid_cyc) bus.addr_in = 3'd2;
            if (fired) begin
                i++;
                hs++;
            end
            if (bus.ssel) ssel_cyc++;
            if (bus.ssel && bus.saddr !== addr) saddr_bad++;
            if (bus.busy !== bus.ssel) busy_bad++;
            if (bus.byte_ready && (bus.sclk || !bus.ssel))
                ready_bad++;
            if (bus.sclk && psclk && bus.sin !== psin)
                sin_bad++;
            if (bus.sclk && !psclk) begin
                if (got_bits.size() % W != 0 && lo_run != DIV)
                    lo_bad++;
                got_bits.push_back(bus.sin);
                rises++;
                hi_run = 0;
            end
            if (!bus.sclk && psclk && hi_run != DIV) hi_bad++;
            if (bus.sclk) begin
                hi_run++;
                lo_run = 0;
            end else begin
                lo_run++;
            end
            psclk = bus.sclk;
            psin  = bus.sin;
`ifdef READBACK_EN
            if (bus.rb_valid) begin
                rb_cnt++;
                if (bus.rb_byte !== pat) rb_bad++;
            end
            // returned data lags sin: bit k of pattern per rise
            bus.sout = (rises > 0) ? pat[W - 1 - ((rises - 1) % W)]
                                   : 1'b0;
`endif
            if (bus.done) begin
                dones++;
                break;
            end
            if (reset_rise >= 0 && rises == reset_rise) begin
                reset = 1'b1;
                bus.byte_valid = 1'b0;
                break;
            end
            if (i == stall_byte && !stalled && bus.byte_ready) begin
                stall_left = 10;
                stalled = 1;
            end
            if (stall_left > 0) begin
                bus.byte_valid = 1'b0;
                stall_left--;
            end else begin
                bus.byte_valid = (i < SIZE);
            end
            bus.byte_in = (i < SIZE) ? tx[i] : W'($urandom);
            fired = bus.byte_valid && bus.byte_ready;
        end
        timed_out = (c > 3000);
    endtask

    task automatic check_frame(input string t, input int extra);
        check({t, "_timeout"}, 32'(timed_out), 0);
        check({t, "_bits"}, stream_diff(), 0);
        check({t, "_handshakes"}, hs, SIZE);
        check({t, "_done"}, dones, 1);
        check({t, "_ssel_cycles"}, ssel_cyc, FRM + extra);
        check({t, "_timing"}, hi_bad + lo_bad + sin_bad, 0);
        check({t, "_saddr"}, saddr_bad, 0);
        check({t, "_busy_ready"}, busy_bad + ready_bad, 0);
    endtask

    initial begin
        logic [5:0] any;
        logic [W-1:0] fb;
        bus.start      = 1'b0;
        bus.addr_in    = 3'd0;
        bus.byte_in    = '0;
        bus.byte_valid = 1'b0;
        bus.sout       = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // idle with stray valid bytes present
        any = '0;
        bus.byte_valid = 1'b1;
        repeat (20) begin
            @(negedge clk);
            bus.byte_in = W'($urandom);
            any |= {bus.ssel, bus.sclk, bus.sin,
                    bus.busy, bus.byte_ready, bus.done};
        end
        bus.byte_valid = 1'b0;
        check("idle_ssel", 32'(any[5]), 0);
        check("idle_sclk", 32'(any[4]), 0);
        check("idle_sin", 32'(any[3]), 0);
        check("idle_busy", 32'(any[2]), 0);
        check("idle_ready", 32'(any[1]), 0);
        check("idle_done", 32'(any[0]), 0);
        check("idle_saddr", 32'(bus.saddr), 0);

        new_bytes(8'hA5);
        run_frame(3'd5, -1, -1, -1);
        check_frame("basic", 0);
        fb = '0;
        for (int k = 0; k < W && k < got_bits.size(); k++)
            fb = {fb[W-2:0], got_bits[k]};
        check("first_byte", 32'(fb), 32'hA5);

        // start coinciding with done must be dropped
        bus.start   = 1'b1;
        bus.addr_in = 3'd1;
        @(negedge clk);
        bus.start = 1'b0;
        check("start_on_done_busy", 32'(bus.busy), 0);
        check("start_on_done_ssel", 32'(bus.ssel), 0);

        run_frame(3'd5, 4, -1, -1);
        check_frame("stall", 10);

        new_bytes(W'($urandom));
        run_frame(3'd5, -1, 100, -1);
        check_frame("midstart", 0);

        new_bytes(W'($urandom));
        run_frame(3'd5, -1, -1, 5 * W + 3);
        check("rst_timeout", 32'(timed_out), 0);
        @(negedge clk);
        check("rst_outputs", 32'({bus.ssel, bus.sclk, bus.busy,
                                  bus.byte_ready, bus.sin,
                                  bus.done}), 0);
        check("rst_saddr", 32'(bus.saddr), 0);
        check("rst_no_done", dones, 0);
        reset = 1'b0;
        @(negedge clk);
        new_bytes(W'($urandom));
        run_frame(3'd6, -1, -1, -1);
        check_frame("after_rst", 0);
`ifdef READBACK_EN
        check("rb_pulses", rb_cnt, SIZE);
        check("rb_bytes", rb_bad, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
